// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler: source indices, vector defaults,
// IE bit positions, FSM state encodings and the vector address helper.
package int_sched_pkg;

    typedef enum int {
        SRC_INT0 = 0,
        SRC_T0   = 1,
        SRC_INT1 = 2,
        SRC_T1   = 3,
        SRC_SER  = 4
    } src_id_t;

    localparam int          NUM_SRC_DEF    = 5;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0003;
    localparam int          VEC_STRIDE_DEF = 8;
    localparam int          IE_EA_BIT      = 7;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } sched_state_t;

    // Vector address wraps silently at 16 bits.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input int          stride,
                                             input int          idx);
        int sum;
        sum = int'(base) + stride * idx;
        return sum[15:0];
    endfunction

endpackage

// File: rtl/int_sched_prio_enc.sv
// Fixed-priority encoder: any high-level source beats any low-level source,
// and within a level the lowest index wins.
module int_prio_enc
    import int_sched_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_SRC-1:0] allowed,
    input  logic [NUM_SRC-1:0] ip,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               winner_lvl,
    output logic               valid
);

    logic [NUM_SRC-1:0] hi_mask;
    logic [NUM_SRC-1:0] sel_mask;

    always_comb begin
        hi_mask    = allowed & ip;
        valid      = |allowed;
        winner_lvl = |hi_mask;
        sel_mask   = winner_lvl ? hi_mask : allowed;
        winner_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (sel_mask[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: qualifies requests with IE/IP, arbitrates, hands one vector
// to the CPU and tracks two-level nesting. Define INT_SCHED_HOLDOFF_EN to block
// arbitration for 2 cycles after every RETI.
module int_sched
    import int_sched_pkg::*;
#(
    parameter int          NUM_SRC    = NUM_SRC_DEF,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         ie,
    input  logic [7:0]         ip,
    input  logic [NUM_SRC-1:0] req,
    input  logic               int_ack,
    input  logic               reti,
    output logic               irq,
    output logic [15:0]        vector,
    output logic [NUM_SRC-1:0] clr_flag,
    output logic [1:0]         in_service
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    sched_state_t       state, state_nxt;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] allowed;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_lvl;
    logic               enc_valid;
    logic [IDX_W-1:0]   win_idx, win_idx_nxt;
    logic               win_lvl, win_lvl_nxt;
    logic               irq_nxt;
    logic [15:0]        vector_nxt;
    logic [NUM_SRC-1:0] clr_nxt;
    logic [1:0]         svc_reti;
    logic [1:0]         svc_nxt;
    logic               arb_block;
    logic               unused_bits;

    assign unused_bits = ^{ie[IE_EA_BIT-1:NUM_SRC], ip[7:NUM_SRC]};

    assign elig = req & ie[NUM_SRC-1:0] & {NUM_SRC{ie[IE_EA_BIT]}};

    // A running high-level ISR blocks everything; a low-level one admits only high sources.
    always_comb begin
        allowed = '0;
        if (in_service[1]) begin
            allowed = '0;
        end else if (in_service[0]) begin
            allowed = elig & ip[NUM_SRC-1:0];
        end else begin
            allowed = elig;
        end
    end

    int_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .allowed    (allowed),
        .ip         (ip[NUM_SRC-1:0]),
        .winner_idx (enc_idx),
        .winner_lvl (enc_lvl),
        .valid      (enc_valid)
    );

`ifdef INT_SCHED_HOLDOFF_EN
    logic [1:0] holdoff_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            holdoff_cnt <= 2'd0;
        end else if (reti) begin
            holdoff_cnt <= 2'd2;
        end else if (holdoff_cnt != 2'd0) begin
            holdoff_cnt <= holdoff_cnt - 2'd1;
        end
    end

    assign arb_block = reti | (holdoff_cnt != 2'd0);
`else
    assign arb_block = 1'b0;
`endif

    // RETI retires the innermost (highest) active level before any same-cycle ack lands.
    always_comb begin
        svc_reti = in_service;
        if (reti) begin
            if (in_service[1]) begin
                svc_reti[1] = 1'b0;
            end else begin
                svc_reti[0] = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        irq_nxt     = irq;
        vector_nxt  = vector;
        win_idx_nxt = win_idx;
        win_lvl_nxt = win_lvl;
        clr_nxt     = '0;
        svc_nxt     = svc_reti;
        case (state)
            IDLE: begin
                if (enc_valid && !arb_block) begin
                    win_idx_nxt = enc_idx;
                    win_lvl_nxt = enc_lvl;
                    vector_nxt  = vec_addr(VEC_BASE, VEC_STRIDE, int'(enc_idx));
                    irq_nxt     = 1'b1;
                    state_nxt   = PEND;
                end
            end
            PEND: begin
                if (int_ack) begin
                    irq_nxt          = 1'b0;
                    svc_nxt[win_lvl] = 1'b1;
                    if (int'(win_idx) != SRC_SER) begin
                        clr_nxt[win_idx] = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (!elig[win_idx]) begin
                    irq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                irq_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            irq        <= 1'b0;
            vector     <= '0;
            win_idx    <= '0;
            win_lvl    <= 1'b0;
            clr_flag   <= '0;
            in_service <= '0;
        end else begin
            state      <= state_nxt;
            irq        <= irq_nxt;
            vector     <= vector_nxt;
            win_idx    <= win_idx_nxt;
            win_lvl    <= win_lvl_nxt;
            clr_flag   <= clr_nxt;
            in_service <= svc_nxt;
        end
    end

endmodule

// File: tb/tb_int_sched.sv
// Directed testbench for int_sched; expectations for the INT_SCHED_HOLDOFF_EN
// build are selected with the same macro.
module tb_int_sched;

    logic        clk;
    logic        reset;
    logic [7:0]  ie;
    logic [7:0]  ip;
    logic [4:0]  req;
    logic        int_ack;
    logic        reti;
    logic        irq;
    logic [15:0] vector;
    logic [4:0]  clr_flag;
    logic [1:0]  in_service;

    int n_checks = 0;
    int n_fails  = 0;

    int_sched dut (
        .clk        (clk),
        .reset      (reset),
        .ie         (ie),
        .ip         (ip),
        .req        (req),
        .int_ack    (int_ack),
        .reti       (reti),
        .irq        (irq),
        .vector     (vector),
        .clr_flag   (clr_flag),
        .in_service (in_service)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset   = 1'b0;
        ie      = 8'h00;
        ip      = 8'h00;
        req     = 5'b0;
        int_ack = 1'b0;
        reti    = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        n_checks++; if (vector !== 16'h0000) begin n_fails++; $display("[TB] FAIL reset_vector: got %h expected 0000", vector); end
        n_checks++; if (clr_flag !== 5'b0) begin n_fails++; $display("[TB] FAIL reset_clr: got %b expected 00000", clr_flag); end
        n_checks++; if (in_service !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_svc: got %b expected 00", in_service); end
    endtask

    task automatic test_basic();
        reset_dut();
        ie = 8'h82; ip = 8'h00; req = 5'b00010;
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL basic_latency: got %b expected 0", irq); end
        tick();
        n_checks++; if (irq !== 1'b1) begin n_fails++; $display("[TB] FAIL basic_irq: got %b expected 1", irq); end
        n_checks++; if (vector !== 16'h000B) begin n_fails++; $display("[TB] FAIL basic_vector: got %h expected 000b", vector); end
        int_ack = 1'b1; req = 5'b0;
        tick();
        int_ack = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL basic_irq_drop: got %b expected 0", irq); end
        n_checks++; if (clr_flag !== 5'b00010) begin n_fails++; $display("[TB] FAIL basic_clr: got %b expected 00010", clr_flag); end
        n_checks++; if (in_service !== 2'b01) begin n_fails++; $display("[TB] FAIL basic_svc: got %b expected 01", in_service); end
        tick();
        n_checks++; if (clr_flag !== 5'b0) begin n_fails++; $display("[TB] FAIL basic_clr_pulse: got %b expected 00000", clr_flag); end
        // An ack outside PEND must change nothing.
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        n_checks++; if ({irq, clr_flag, in_service} !== {1'b0, 5'b0, 2'b01}) begin n_fails++; $display("[TB] FAIL stray_ack: got %b/%b/%b expected 0/00000/01", irq, clr_flag, in_service); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_checks++; if (in_service !== 2'b00) begin n_fails++; $display("[TB] FAIL basic_reti: got %b expected 00", in_service); end
    endtask

    task automatic test_same_level();
        int cyc;
        reset_dut();
        ie = 8'h9F; ip = 8'h00; req = 5'b10101;
        tick();
        n_checks++; if (vector !== 16'h0003) begin n_fails++; $display("[TB] FAIL order_first: got %h expected 0003", vector); end
        int_ack = 1'b1; req = 5'b10100;
        tick();
        int_ack = 1'b0;
        n_checks++; if (clr_flag !== 5'b00001) begin n_fails++; $display("[TB] FAIL order_clr: got %b expected 00001", clr_flag); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        cyc = 0;
        while (irq !== 1'b1 && cyc < 8) begin tick(); cyc++; end
        n_checks++; if (irq !== 1'b1) begin n_fails++; $display("[TB] FAIL order_timeout: got irq %b expected 1", irq); end
        n_checks++; if (vector !== 16'h0013) begin n_fails++; $display("[TB] FAIL order_second: got %h expected 0013", vector); end
    endtask

    task automatic test_preempt();
        int cyc;
        reset_dut();
        ie = 8'h9F; ip = 8'h0A; req = 5'b00001;
        tick();
        int_ack = 1'b1; req = 5'b0;
        tick();
        int_ack = 1'b0;
        req = 5'b01000;
        tick();
        n_checks++; if (vector !== 16'h001B || irq !== 1'b1) begin n_fails++; $display("[TB] FAIL preempt_vector: got %h/%b expected 001b/1", vector, irq); end
        int_ack = 1'b1; req = 5'b0;
        tick();
        int_ack = 1'b0;
        n_checks++; if (in_service !== 2'b11) begin n_fails++; $display("[TB] FAIL preempt_svc: got %b expected 11", in_service); end
        req = 5'b00010;
        tick(); tick(); tick();
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL high_isr_block: got %b expected 0", irq); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_checks++; if (in_service !== 2'b01) begin n_fails++; $display("[TB] FAIL preempt_reti: got %b expected 01", in_service); end
        cyc = 0;
        while (irq !== 1'b1 && cyc < 8) begin tick(); cyc++; end
        n_checks++; if (irq !== 1'b1 || vector !== 16'h000B) begin n_fails++; $display("[TB] FAIL nest_after_reti: got %b/%h expected 1/000b", irq, vector); end
    endtask

    task automatic test_serial_cancel();
        reset_dut();
        ie = 8'h90; req = 5'b10000;
        tick();
        n_checks++; if (vector !== 16'h0023) begin n_fails++; $display("[TB] FAIL serial_vector: got %h expected 0023", vector); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        n_checks++; if (clr_flag !== 5'b0 || in_service !== 2'b01) begin n_fails++; $display("[TB] FAIL serial_ack: got %b/%b expected 00000/01", clr_flag, in_service); end
        reset_dut();
        ie = 8'h82; req = 5'b00010;
        tick();
        ie = 8'h02;
        tick();
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL cancel_irq: got %b expected 0", irq); end
        ie = 8'h82;
        tick();
        n_checks++; if (irq !== 1'b1) begin n_fails++; $display("[TB] FAIL cancel_rearm: got %b expected 1", irq); end
    endtask

    task automatic test_reti_ack();
        reset_dut();
        ie = 8'h89; ip = 8'h08; req = 5'b00001;
        tick();
        int_ack = 1'b1; req = 5'b0;
        tick();
        int_ack = 1'b0;
        req = 5'b01000;
        tick();
        reti = 1'b1; int_ack = 1'b1; req = 5'b0;
        tick();
        reti = 1'b0; int_ack = 1'b0;
        n_checks++; if (in_service !== 2'b10) begin n_fails++; $display("[TB] FAIL reti_ack_svc: got %b expected 10", in_service); end
        n_checks++; if (clr_flag !== 5'b01000) begin n_fails++; $display("[TB] FAIL reti_ack_clr: got %b expected 01000", clr_flag); end
    endtask

    task automatic test_reset_pend();
        reset_dut();
        ie = 8'h82; req = 5'b00010;
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({irq, vector, clr_flag, in_service} !== 24'h0) begin n_fails++; $display("[TB] FAIL reset_pend: got %b/%h/%b/%b expected all 0", irq, vector, clr_flag, in_service); end
        reset = 1'b1;
        tick();
        n_checks++; if (irq !== 1'b1 || vector !== 16'h000B) begin n_fails++; $display("[TB] FAIL reset_rearm: got %b/%h expected 1/000b", irq, vector); end
    endtask

    task automatic test_holdoff();
        int cyc;
        int exp_cyc;
`ifdef INT_SCHED_HOLDOFF_EN
        exp_cyc = 3;
`else
        exp_cyc = 1;
`endif
        reset_dut();
        ie = 8'h83; req = 5'b00010;
        tick();
        int_ack = 1'b1; req = 5'b00001;
        tick();
        int_ack = 1'b0;
        tick(); tick();
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL holdoff_blocked: got %b expected 0", irq); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        cyc = 0;
        while (irq !== 1'b1 && cyc < 8) begin tick(); cyc++; end
        n_checks++; if (cyc !== exp_cyc) begin n_fails++; $display("[TB] FAIL reti_to_irq: got %0d cycles expected %0d", cyc, exp_cyc); end
        n_checks++; if (vector !== 16'h0003) begin n_fails++; $display("[TB] FAIL holdoff_vector: got %h expected 0003", vector); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_level();
        test_preempt();
        test_serial_cancel();
        test_reti_ack();
        test_reset_pend();
        test_holdoff();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Interrupt scheduler between the five MCU interrupt sources and the CPU core.
- Qualifies raw requests with IE and IP, then arbitrates by priority level and natural order.
- Presents one vector to the CPU with a request/acknowledge handshake.
- Tracks two-level nesting and clears hardware-cleared flags in TCON.

Parameters:
- NUM_SRC, 5, number of interrupt sources: 0=INT0, 1=T0, 2=INT1, 3=T1, 4=serial.
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, address spacing between consecutive source vectors.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ie  in  8  IE SFR; bit7 = global enable EA, bits[4:0] = per-source enables.
- ip  in  8  IP SFR; bits[4:0] = per-source high-priority select.
- req  in  NUM_SRC  raw pending flags (TCON IE0/TF0/IE1/TF1, SCON RI|TI).
- int_ack  in  1  one-cycle pulse: CPU has taken the vector.
- reti  in  1  one-cycle pulse: CPU executed RETI.
- irq  out  1  interrupt request to CPU.
- vector  out  16  target address; valid and stable while irq=1.
- clr_flag  out  NUM_SRC  one-cycle pulse clearing the taken source's flag.
- in_service  out  2  bit1 = high-level ISR active, bit0 = low-level ISR active.

Behaviour:
- Reset (reset=0 at clk edge): irq=0, vector=0, clr_flag=0, in_service=0, state=IDLE.
- Eligibility: elig[i] = req[i] & ie[i] & ie[7].
- Level of source i: ip[i].
- Preemption threshold:
  - in_service[1]=1: no new request is eligible.
  - in_service=2'b01: only ip[i]=1 sources are eligible.
  - in_service=2'b00: all eligible sources compete.
- Winner: among allowed sources, any high-level source beats any low-level source. Within a level, the lowest index wins.
- IDLE:
  - When a winner exists, latch its index w and level.
  - Drive vector = VEC_BASE + VEC_STRIDE*w and irq=1 from the next cycle (1-cycle latency). Go to PEND.
- PEND:
  - irq and vector are held stable. A newly arriving higher-priority request does not replace the latched winner.
  - If int_ack=1: irq=0 next cycle, in_service[level] set, return to IDLE.
  - On the same ack, clr_flag[w] pulses one cycle, except w=4: the serial flag is software-cleared and its clr_flag bit stays 0.
  - If int_ack=0 and elig[w] has dropped (flag cleared or IE changed): cancel, irq=0 next cycle, return to IDLE.
- reti: clears the highest set in_service bit; no effect if in_service=0.
- reti and int_ack in the same cycle: apply reti first, then ack.
- int_ack while not in PEND: ignored, no state or output change.
- vector arithmetic is 16-bit unsigned, with wrap-around beyond 16'hFFFF ignored.
- Reset asserted mid-PEND or mid-ISR: all state is discarded; the first irq is possible 1 cycle after reset deassertion.

Optional Feature:
- Macro: INT_SCHED_HOLDOFF_EN.
- Defined: after any reti pulse, IDLE arbitration is suppressed for exactly 2 cycles, so irq cannot rise within 2 cycles of RETI. This guarantees one main-line instruction executes between ISRs.
- Undefined: arbitration resumes in the cycle after reti, and irq may assert 1 cycle after it.

Decomposition:
- Shared package para.vh:
  - source index constants SRC_INT0..SRC_SER;
  - VEC_BASE and VEC_STRIDE defaults;
  - IE EA bit position;
  - state encodings IDLE and PEND.
- Sub-module int_prio_enc: combinational fixed-priority encoder. Inputs: allowed mask and ip. Outputs: winner index, winner level, valid.

Test Plan:
- Basic service: ie=8'h82, ip=0, req=5'b00010 → irq=1 one cycle later, vector=16'h000B. int_ack → clr_flag=5'b00010 for 1 cycle, in_service=2'b01, irq=0.
- Same-level order: ie=8'h9F, ip=0, req=5'b10101 → vector=16'h0003. After ack and reti with req=5'b10100 → vector=16'h0013.
- Priority and preemption: ip=8'h08. During low ISR of source 0, req[3]=1 → vector=16'h001B, in_service=2'b11. During that high ISR, req[1] raised → irq stays 0. reti → in_service=2'b01.
- Serial and cancel: req[4]=1 acked → clr_flag=0, in_service set. Separately, in PEND clear ie[7] → irq drops next cycle, state returns to IDLE.
- Edge cases:
  - simultaneous reti and int_ack → in_service reflects reti then set;
  - reset during PEND → all outputs 0;
  - with INT_SCHED_HOLDOFF_EN → irq no earlier than 3 cycles after reti.
